// File: rtl/scan_pkg.sv
// Shared types and constants for the channel-scan sequencer.
package scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_e;

endpackage

// File: rtl/next_chan_finder.sv
// Wrap-around priority search for the next enabled channel after cur.
// In first mode the search starts below channel 0, which yields the lowest set bit.
module next_chan_finder (
    input  logic [scan_pkg::NUM_CH-1:0] mask,
    input  logic [scan_pkg::IDX_W-1:0]  cur,
    input  logic                        first_mode,
    output logic [scan_pkg::IDX_W-1:0]  nxt,
    output logic                        wrap
);
    import scan_pkg::*;

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan candidates in ascending order from cur+1 (or from 0 in first mode); first hit wins.
    always_comb begin
        nxt   = '0;
        wrap  = 1'b0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            if (first_mode) begin
                idx = IDX_W'(i - 1);
            end else begin
                idx = IDX_W'(int'(cur) + i);
            end
            if (!found && mask[idx]) begin
                found = 1'b1;
                nxt   = idx;
                wrap  = !first_mode && (idx <= cur);
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Channel-scan sequencer: steps through a latched channel mask, holding each
// enabled channel for dwell+1 cycles, in single-pass or continuous mode.
module scan_sequencer #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned NUM_CH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        continuous,
    input  logic [NUM_CH-1:0]           chan_mask,
    input  logic [DWELL_W-1:0]          dwell,
    output logic [$clog2(NUM_CH)-1:0]   sel,
    output logic                        sel_valid,
    output logic                        busy,
    output logic                        pass_done,
    output logic                        done,
    output logic                        err
);
    import scan_pkg::*;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               cont_q, cont_d;
    logic               stop_pend_q, stop_pend_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               pass_done_q, pass_done_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NUM_CH-1:0]  find_mask;
    logic               find_first;
    logic [IDX_W-1:0]   find_nxt;
    logic               find_wrap;

    // One shared search: first-channel lookup on the live mask when idle,
    // successor lookup on the latched mask while scanning.
    assign find_first = (state_q == IDLE);
    assign find_mask  = find_first ? chan_mask : mask_q;

    next_chan_finder u_finder (
        .mask       (find_mask),
        .cur        (sel_q),
        .first_mode (find_first),
        .nxt        (find_nxt),
        .wrap       (find_wrap)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        pass_done_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    if (chan_mask != '0) begin
                        mask_d      = chan_mask;
                        dwell_d     = dwell;
                        cont_d      = continuous;
                        sel_d       = find_nxt;
                        cnt_d       = dwell;
                        state_d     = DWELL;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            DWELL: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    // End of dwell: a wrap closes the pass; a pending stop
                    // recorded before this edge ends the scan here.
                    pass_done_d = find_wrap;
                    if ((find_wrap && !cont_q) || stop_pend_q) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        sel_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        stop_pend_d = 1'b0;
                    end else begin
                        sel_d = find_nxt;
                        cnt_d = dwell_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset is asynchronous and silent (no done).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign pass_done = pass_done_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed table, hand-written corner
// sequences and random traffic against a queue-based scan model.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] chan_mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic [2:0] sel;
    logic       sel_valid, busy, pass_done, done, err;

    int n_checks = 0;
    int n_err    = 0;

    scan_sequencer #(.DWELL_W(8), .NUM_CH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .pass_done  (pass_done),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (list of enabled channels + hold count)
    int   m_ch[$];
    int   m_pos, m_hold, m_dw, m_sel;
    bit   m_busy, m_cont, m_stop, m_pass, m_done, m_err;

    task automatic model_reset();
        m_ch.delete();
        m_pos = 0; m_hold = 0; m_dw = 0; m_sel = 0;
        m_busy = 0; m_cont = 0; m_stop = 0;
        m_pass = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit ct,
                              input logic [7:0] mk, input logic [7:0] dw);
        bit stop_old;
        bit last;
        m_pass = 0; m_done = 0; m_err = 0;
        if (!m_busy) begin
            if (st) begin
                if (mk == 8'h00) begin
                    m_err = 1;
                end else begin
                    m_ch.delete();
                    for (int i = 0; i < 8; i++) if (mk[i]) m_ch.push_back(i);
                    m_pos = 0; m_hold = 0; m_sel = m_ch[0];
                    m_dw = int'(dw); m_cont = ct; m_busy = 1; m_stop = 0;
                end
            end
        end else begin
            stop_old = m_stop;
            if (sp) m_stop = 1;
            m_hold++;
            if (m_hold > m_dw) begin
                last   = (m_pos == m_ch.size() - 1);
                m_pass = last;
                if ((last && !m_cont) || stop_old) begin
                    m_busy = 0; m_done = 1; m_stop = 0;
                end else begin
                    m_pos  = last ? 0 : m_pos + 1;
                    m_sel  = m_ch[m_pos];
                    m_hold = 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] ex(input int s, input bit v, input bit b,
                                      input bit p, input bit d, input bit e);
        return {3'(s), v, b, p, d, e};
    endfunction

    function automatic logic [7:0] model_vec();
        return ex(m_sel, m_busy, m_busy, m_pass, m_done, m_err);
    endfunction

    function automatic logic [7:0] dut_vec();
        return {sel, sel_valid, busy, pass_done, done, err};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %b want %b (sel[3],valid,busy,pass,done,err)",
                     name, $time, got, want);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cyc(input bit st, input bit sp, input bit ct,
                       input logic [7:0] mk, input logic [7:0] dw,
                       output logic [7:0] got);
        start = st; stop = sp; continuous = ct; chan_mask = mk; dwell = dw;
        @(posedge clk);
        model_step(st, sp, ct, mk, dw);
        #1;
        got = dut_vec();
        check("model", got, model_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 0; stop = 0; continuous = 0; chan_mask = 0; dwell = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_state", dut_vec(), 8'h00);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         st, sp, ct;
        logic [7:0] mk, dw;
        logic [7:0] exp;
    } vec_t;

    vec_t vec[16];
    int   seq[4] = '{0, 2, 5, 7};
    logic [7:0] g;
    int   cnt;

    initial begin
        // ---- directed table: single pass over 8'hA5, dwell 2, then mask==0 error
        vec[0] = '{1, 0, 0, 8'hA5, 8'd2, ex(0, 1, 1, 0, 0, 0)};
        for (int i = 1; i < 12; i++)
            vec[i] = '{0, 0, 0, 8'hA5, 8'd2, ex(seq[i / 3], 1, 1, 0, 0, 0)};
        vec[12] = '{0, 0, 0, 8'h00, 8'd0, ex(7, 0, 0, 1, 1, 0)};
        vec[13] = '{0, 1, 0, 8'h00, 8'd0, ex(7, 0, 0, 0, 0, 0)};
        vec[14] = '{1, 1, 1, 8'h00, 8'd3, ex(7, 0, 0, 0, 0, 1)};
        vec[15] = '{0, 0, 0, 8'h00, 8'd0, ex(7, 0, 0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(vec[i].st, vec[i].sp, vec[i].ct, vec[i].mk, vec[i].dw, g);
            check($sformatf("table[%0d]", i), g, vec[i].exp);
        end

        // ---- single channel continuous, then stop: one more cycle, then done+pass_done
        cyc(1, 0, 1, 8'h10, 8'd0, g);
        check("single_first", g, ex(4, 1, 1, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 8'd0, g);
        check("single_pass_each_cycle", g, ex(4, 1, 1, 1, 0, 0));
        cyc(0, 0, 0, 8'h00, 8'd0, g);
        cyc(0, 1, 0, 8'h00, 8'd0, g);
        check("stop_extra_cycle", g, ex(4, 1, 1, 1, 0, 0));
        cyc(0, 0, 0, 8'h00, 8'd0, g);
        check("stop_done_with_pass", g, ex(4, 0, 0, 1, 1, 0));
        cyc(0, 0, 0, 8'h00, 8'd0, g);
        check("after_stop_idle", g, ex(4, 0, 0, 0, 0, 0));

        // ---- all channels, dwell 0, continuous: 0..7,0..7,0..3
        cyc(1, 0, 1, 8'hFF, 8'd0, g);
        check("ff_sel[0]", g, ex(0, 1, 1, 0, 0, 0));
        for (int i = 1; i < 20; i++) begin
            cyc(0, 0, 0, 8'h00, 8'd0, g);
            check($sformatf("ff_sel[%0d]", i), g, ex(i % 8, 1, 1, (i % 8) == 0, 0, 0));
        end
        cyc(0, 1, 0, 8'h00, 8'd0, g);
        cnt = 0;
        while (busy && cnt < 20) begin
            cyc(0, 0, 0, 8'h00, 8'd0, g);
            cnt++;
        end
        check("ff_stop_terminated", {7'd0, busy}, 8'h00);

        // ---- async reset mid-dwell on sel=7; outputs clear before the next edge
        cyc(1, 0, 1, 8'h81, 8'd5, g);
        for (int i = 1; i < 8; i++) cyc(0, 0, 0, 8'h00, 8'd0, g);
        check("pre_reset_sel7", g, ex(7, 1, 1, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 check("async_reset_immediate", dut_vec(), 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check("reset_held_no_done", dut_vec(), 8'h00);
        cyc(0, 0, 0, 8'h00, 8'd0, g);
        check("post_reset_no_done", g, 8'h00);
        cyc(1, 0, 0, 8'h81, 8'd5, g);
        check("restart_sel0", g, ex(0, 1, 1, 0, 0, 0));
        do_reset();

        // ---- start while busy ignored; start held through done is taken at the done edge
        cyc(1, 0, 0, 8'h03, 8'd0, g);
        check("busy_first", g, ex(0, 1, 1, 0, 0, 0));
        cyc(1, 0, 0, 8'hF0, 8'd0, g);
        check("busy_start_ignored", g, ex(1, 1, 1, 0, 0, 0));
        cyc(1, 0, 0, 8'hF0, 8'd0, g);
        check("busy_done", g, ex(1, 0, 0, 1, 1, 0));
        cyc(1, 0, 0, 8'hF0, 8'd0, g);
        check("restart_at_done", g, ex(4, 1, 1, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 8'd0, g);
        check("restart_next", g, ex(5, 1, 1, 0, 0, 0));

        // ---- random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rm;
            rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                1'($urandom), rm, 8'($urandom_range(0, 3)), g);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Upstream channel-scan sequencer that generates the 3-bit channel index consumed by the team's 3-to-8 one-hot decoder. Once started, it steps through the enabled channels in a latched 8-bit mask in ascending order, wrapping from 7 to 0. Each selected channel is held for a programmable dwell time. It runs either a single pass or continuously, and reports pass completion and termination with single-cycle pulses.

## Interface
- DWELL_W, 8, width of the dwell-count input
- NUM_CH, 8, number of channels (fixed; sel width = 3)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level sampled each cycle; starts a scan when idle
- stop  in  1  requests graceful termination while busy
- continuous  in  1  1 = repeat passes, 0 = single pass; latched at start
- chan_mask  in  8  enabled channels; latched at start
- dwell  in  DWELL_W  hold count; each channel held dwell+1 cycles; latched at start
- sel  out  3  channel index fed to the decoder
- sel_valid  out  1  sel is meaningful
- busy  out  1  scan in progress
- pass_done  out  1  one-cycle pulse at end of each complete pass
- done  out  1  one-cycle pulse when scan terminates
- err  out  1  one-cycle pulse: start with chan_mask==0

## Operation
- Reset values: sel=0, sel_valid=0, busy=0, pass_done=0, done=0, err=0, state IDLE, dwell counter 0, stop-pending 0.
- States:
  - IDLE: sel_valid=0 and busy=0.
  - DWELL: sel_valid=1 and busy=1.
- IDLE, start=1, chan_mask!=0:
  - latch mask, dwell and continuous
  - sel <= lowest set bit of mask
  - load counter with dwell
  - go to DWELL
- IDLE, start=1, chan_mask==0: err pulses; stay in IDLE.
- IDLE, stop: ignored. Simultaneous start and stop in IDLE behaves as start alone.
- DWELL, counter!=0: decrement the counter.
- DWELL, counter==0 (end of dwell): nxt = next set bit strictly after sel, wrapping 7→0. With a single-bit mask, nxt = sel.
  - Wrap: nxt <= sel. The end of this dwell is the end of a pass, and pass_done pulses.
  - Terminate: when (wrap and continuous==0) or stop-pending. Go to IDLE, pulse done, set sel_valid=0, and hold sel at its last value.
  - Otherwise: sel <= nxt, reload the counter with the latched dwell, stay in DWELL.
- Stop handling:
  - A stop seen in DWELL sets stop-pending.
  - The current dwell always completes; there is no truncation.
  - Stop-pending clears on entry to IDLE.
- Stop and wrap at the same end of dwell: done and pass_done pulse together in the same cycle, once each.
- start while busy: ignored. Mask, dwell and continuous changes while busy have no effect.
- Async reset mid-scan: all outputs return to their reset values immediately, and no done pulse is generated.

## Timing
- start sampled at edge T: at T+1 sel=first channel, sel_valid=1, busy=1.
- Each channel is held exactly dwell+1 cycles. dwell=0 gives a new channel every cycle.
- pass_done and done are registered and high in the cycle after the last dwell cycle. In that same cycle, sel_valid=0 when terminating.
- A new start is accepted on the edge at which done is high. It is honored from IDLE, so there is no dead cycle beyond the done cycle.
- Single-pass duration = popcount(mask)·(dwell+1) cycles of sel_valid.

## Structure
- Package scan_pkg:
  - state enum {IDLE, DWELL}
  - NUM_CH=8
  - IDX_W=3
- Sub-module next_chan_finder: combinational wrap-around priority search.
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: nxt[2:0], wrap.
- The same search, with cur treated as −1, gives the first channel at start; expose this via a first-mode input.

## Test plan
- mask=8'b1010_0101, dwell=2, continuous=0, start pulse → sel sequence 0,2,5,7, each held 3 cycles with sel_valid=1. pass_done and done both pulse at cycle 13 after start. busy falls with them.
- mask=8'b0001_0000, dwell=0, continuous=1 → sel=4 held constantly; pass_done pulses every cycle. stop → exactly one further cycle of sel=4, then done with pass_done, and sel_valid=0.
- mask=8'hFF, dwell=0, continuous=1, run 20 cycles → sel 0..7,0..7,0..3. pass_done pulses after sel=7 each pass.
- start with mask=0 → err pulses 1 cycle; busy, sel_valid and done stay 0.
- mask=8'h81, dwell=5, assert rst_n=0 for 1 cycle mid-dwell on sel=7 → all outputs reset immediately, no done. A subsequent start restarts at sel=0.
- Busy with mask=8'h03; raise start with mask=8'hF0 → ignored, scan continues 0,1. start held high through done → new scan begins at sel=4 one cycle after done.
